// File: rtl/out_to_link_pkg.sv
// out_to_link shared types: state encoding and default ack timeout.
// Optional OUT_LINK_PARITY_EN adds a registered even-parity bit on the link.
package out_to_link_pkg;

  localparam int ACK_TIMEOUT_DEF = 1023;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    REQ   = 3'd2,
    REL   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/out_to_link_if.sv
// Bundle between FIFO_to_out/receiver side and out_to_link.
// Carries tparity only when OUT_LINK_PARITY_EN is defined.
interface out_to_link_if #(
  parameter int DATA_W = 8
);
  logic              isStart;
  logic [DATA_W-1:0] data;
  logic              isFinish;
  logic [DATA_W-1:0] tdata;
  logic              tsent;
  logic              trecieve;
  logic              busy;
  logic              error;
`ifdef OUT_LINK_PARITY_EN
  logic              tparity;

  modport master (
    output isStart, data, trecieve,
    input  isFinish, tdata, tsent, busy, error, tparity
  );
  modport slave (
    input  isStart, data, trecieve,
    output isFinish, tdata, tsent, busy, error, tparity
  );
`else
  modport master (
    output isStart, data, trecieve,
    input  isFinish, tdata, tsent, busy, error
  );
  modport slave (
    input  isStart, data, trecieve,
    output isFinish, tdata, tsent, busy, error
  );
`endif
endinterface

// File: rtl/out_to_link_sync.sv
// link_sync: 2-flop synchroniser for an asynchronous input,
// synchronous active-low reset.
module link_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end
endmodule

// File: rtl/out_to_link.sv
// out_to_link: presents one byte per transaction on a 4-phase link.
// Define OUT_LINK_PARITY_EN to add the tparity output.
module out_to_link
  import out_to_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
  input logic          clk,
  input logic          reset,
  out_to_link_if.slave lnk
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t          state, nxt;
  logic [3:0]      scnt;
  logic [TW-1:0]   tcnt;
  logic            ackS;
  logic            tmo;
  logic            tsentN;
  logic            finN;
  logic            busyN;
  logic            errN;

  link_sync uSync (
    .clk   (clk),
    .reset (reset),
    .din   (lnk.trecieve),
    .dout  (ackS)
  );

  assign tmo = (tcnt == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      scnt         <= 4'd0;
      tcnt         <= '0;
      lnk.tdata    <= {DATA_W{1'b0}};
      lnk.tsent    <= 1'b0;
      lnk.isFinish <= 1'b0;
      lnk.busy     <= 1'b0;
      lnk.error    <= 1'b0;
`ifdef OUT_LINK_PARITY_EN
      lnk.tparity  <= 1'b0;
`endif
    end else begin
      state        <= nxt;
      lnk.tsent    <= tsentN;
      lnk.isFinish <= finN;
      lnk.busy     <= busyN;
      lnk.error    <= errN;
      if (state == IDLE && lnk.isStart) begin
        lnk.tdata <= lnk.data;
        scnt      <= 4'(SETUP_CYCLES);
`ifdef OUT_LINK_PARITY_EN
        lnk.tparity <= ^lnk.data;
`endif
      end else if (state == SETUP) begin
        scnt <= scnt - 4'd1;
      end
      // Timeout count restarts on every state change
      if (nxt != state)
        tcnt <= '0;
      else if (state == REQ || state == REL)
        tcnt <= tcnt + 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (lnk.isStart) nxt = SETUP;
      SETUP:   if (scnt <= 4'd1) nxt = REQ;
      REQ: begin
        if (ackS)     nxt = REL;
        else if (tmo) nxt = DONE;
      end
      REL: begin
        if (!ackS)    nxt = DONE;
        else if (tmo) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    tsentN = (nxt == REQ);
    finN   = (nxt == DONE);
    busyN  = (nxt != IDLE);
    errN   = lnk.error;
    if (state == IDLE && lnk.isStart)
      errN = 1'b0;
    else if ((state == REQ && !ackS && tmo) ||
             (state == REL && ackS && tmo))
      errN = 1'b1;
  end
endmodule

// File: tb/tb_out_to_link.sv
// Randomised scoreboard bench for out_to_link.
// Honours OUT_LINK_PARITY_EN when defined.
module tb_out_to_link;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  out_to_link_if #(.DATA_W(8)) lnk ();

  out_to_link #(
    .DATA_W       (8),
    .SETUP_CYCLES (1),
    .ACK_TIMEOUT  (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .lnk   (lnk)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         err;
    int         hi;
  } exp_t;

  exp_t q[$];
  int   nVec = 0;
  int   nBad = 0;
  int   hiCnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every isFinish pulse must match the oldest accepted start
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      q.delete();
      hiCnt = 0;
    end else begin
      if (lnk.tsent) hiCnt++;
      if (lnk.isFinish) begin
        if (q.size() == 0) begin
          chk("unexpected_finish", 1, 0);
        end else begin
          e = q.pop_front();
          chk("fin_tdata", lnk.tdata, e.d);
          chk("fin_error", lnk.error, e.err);
          chk("tsent_high_cycles", hiCnt, e.hi);
          chk("fin_tsent", lnk.tsent, 0);
          chk("fin_busy", lnk.busy, 1);
`ifdef OUT_LINK_PARITY_EN
          chk("fin_tparity", lnk.tparity, ^e.d);
`endif
        end
        hiCnt = 0;
      end
    end
  end

  task automatic waitIdle(input string nm);
    int n = 0;
    while (lnk.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, lnk.busy, 0);
  endtask

  task automatic startPulse(input logic [7:0] dv);
    @(posedge clk); #1;
    lnk.isStart = 1'b1;
    lnk.data    = dv;
    @(posedge clk); #1;
    lnk.isStart = 1'b0;
    lnk.data    = 8'($urandom);
  endtask

  // d > 13: receiver never acks; d2 > 13: ack held past REL timeout
  task automatic xfer(input logic [7:0] dv, input int d, input int d2,
                      input bit spur);
    exp_t e;
    int   n;
    bit   noAck = (d > TMO - 3);
    e.d   = dv;
    e.err = noAck || (d2 > TMO - 3);
    e.hi  = noAck ? TMO : d + 3;
    q.push_back(e);
    startPulse(dv);
    chk("c1_tdata", lnk.tdata, dv);
    chk("c1_busy", lnk.busy, 1);
    chk("c1_error", lnk.error, 0);
    chk("c1_tsent", lnk.tsent, 0);
    @(posedge clk); #1;
    chk("c2_tsent", lnk.tsent, 1);
    if (spur) begin
      lnk.isStart = 1'b1;
      lnk.data    = 8'h3C;
    end
    if (noAck) begin
      @(posedge clk); #1;
      lnk.isStart = 1'b0;
      waitIdle("idle_after_timeout");
      return;
    end
    for (int i = 0; i < d; i++) begin
      @(posedge clk); #1;
      lnk.isStart = 1'b0;
    end
    lnk.isStart  = 1'b0;
    lnk.trecieve = 1'b1;
    n = 0;
    while (lnk.tsent && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tsent_release", lnk.tsent, 0);
    chk("tdata_hold", lnk.tdata, dv);
    for (int i = 0; i < d2; i++) begin
      @(posedge clk); #1;
    end
    lnk.trecieve = 1'b0;
    waitIdle("idle_after_xfer");
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int d, d2;
    bit spur;
    int n;
    lnk.isStart  = 1'b0;
    lnk.data     = 8'h00;
    lnk.trecieve = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tdata", lnk.tdata, 0);
    chk("rst_tsent", lnk.tsent, 0);
    chk("rst_finish", lnk.isFinish, 0);
    chk("rst_busy", lnk.busy, 0);
    chk("rst_error", lnk.error, 0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("quiet_busy", lnk.busy, 0);
    chk("quiet_tsent", lnk.tsent, 0);

    xfer(8'hA5, 3, 3, 1'b0);
    xfer(8'hA5, 3, 3, 1'b1);
    xfer(8'h5A, 99, 0, 1'b0);
    chk("error_sticky", lnk.error, 1);
    xfer(8'hC3, 0, 0, 1'b0);
    chk("error_cleared", lnk.error, 0);

    // Abort in REQ: no isFinish, immediate return to idle
    startPulse(8'h77);
    @(posedge clk); #1;
    chk("abort_in_req", lnk.tsent, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_tsent", lnk.tsent, 0);
    chk("abort_busy", lnk.busy, 0);
    chk("abort_finish", lnk.isFinish, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    xfer(8'h01, 2, 2, 1'b0);

`ifdef OUT_LINK_PARITY_EN
    xfer(8'h07, 1, 1, 1'b0);
    chk("parity_07", lnk.tparity, 1);
    xfer(8'h03, 1, 1, 1'b0);
    chk("parity_03", lnk.tparity, 0);
`endif

    repeat (40) begin
      d    = $urandom_range(0, 17);
      d2   = $urandom_range(0, 15);
      spur = ($urandom_range(0, 3) == 0);
      if (spur && d == 0) d = 1;
      xfer(8'($urandom), d, d2, spur);
    end

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
